// File: rtl/uart_report_tx.sv
// UART transmitter with byte FIFO and optional 32-bit hex-dump formatter.
// Define UART_HEX_EN to build the formatter (word port); otherwise it is tied off.
`timescale 1ns/1ps
module uart_report_tx #(
    parameter int unsigned CLK_FREQ   = 48_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                          high_clk,
    input  logic                          rst,
    input  logic                          byte_valid,
    input  logic [7:0]                    byte_data,
    output logic                          byte_ready,
    input  logic                          word_valid,
    input  logic [31:0]                   word_data,
    output logic                          word_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned DIV = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [AW:0]   DEPTH_LVL = (AW + 1)'(FIFO_DEPTH);
    localparam logic          TWO_STOP  = (STOP_BITS == 2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic          full;
    logic          empty;
    logic          push_en;
    logic [7:0]    push_data;
    logic          pop_en;
    logic          fmt_busy;

    logic [1:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic          stop_idx;
    logic [7:0]    shreg;
    logic          tx_q;
    logic          bit_end;
    logic          last_stop;

    assign full      = (level == DEPTH_LVL);
    assign empty     = (level == '0);
    assign bit_end   = (baud_cnt == DIV_LAST);
    assign last_stop = !TWO_STOP || stop_idx;
    assign pop_en    = !empty && ((state == S_IDLE) ||
                                  (state == S_STOP && bit_end && last_stop));

    always_ff @(posedge high_clk) begin
        if (push_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge high_clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // tx is registered from the current state, so the line trails the FSM by
    // one cycle; every bit still spans exactly DIV cycles.
    always_ff @(posedge high_clk) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            tx_q     <= 1'b1;
        end else begin
            case (state)
                S_START: tx_q <= 1'b0;
                S_DATA:  tx_q <= shreg[0];
                default: tx_q <= 1'b1;
            endcase

            if (state == S_IDLE || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (pop_en) begin
                        shreg <= mem[rd_ptr];
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        shreg <= shreg >> 1;
                        if (bit_idx == 3'd7) begin
                            stop_idx <= 1'b0;
                            state    <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    if (bit_end) begin
                        if (!last_stop) begin
                            stop_idx <= 1'b1;
                        end else if (pop_en) begin
                            shreg <= mem[rd_ptr];
                            state <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

`ifdef UART_HEX_EN
    logic        fmt_active;
    logic [31:0] fmt_word;
    logic [3:0]  fmt_idx;
    logic        fmt_push;
    logic [7:0]  fmt_char;
    logic [3:0]  nib;

    assign word_ready = !fmt_active && !rst;
    assign byte_ready = !full && !fmt_active && !word_valid && !rst;
    assign fmt_push   = fmt_active && !full;
    assign push_en    = fmt_push || (byte_valid && byte_ready);
    assign push_data  = fmt_push ? fmt_char : byte_data;
    assign fmt_busy   = fmt_active;
    assign nib        = fmt_word[31:28];

    always_comb begin
        fmt_char = 8'h0A;
        if (fmt_idx == 4'd8) begin
            fmt_char = 8'h0D;
        end else if (fmt_idx < 4'd8) begin
            fmt_char = (nib < 4'd10) ? {4'h3, nib} : 8'h37 + {4'h0, nib};
        end
    end

    always_ff @(posedge high_clk) begin
        if (rst) begin
            fmt_active <= 1'b0;
            fmt_word   <= '0;
            fmt_idx    <= '0;
        end else if (word_valid && word_ready) begin
            fmt_active <= 1'b1;
            fmt_word   <= word_data;
            fmt_idx    <= '0;
        end else if (fmt_push) begin
            fmt_word <= fmt_word << 4;
            fmt_idx  <= fmt_idx + 1'b1;
            if (fmt_idx == 4'd9) begin
                fmt_active <= 1'b0;
            end
        end
    end
`else
    logic unused_word;

    assign unused_word = ^{word_valid, word_data};
    assign word_ready  = 1'b0;
    assign byte_ready  = !full && !rst;
    assign push_en     = byte_valid && byte_ready;
    assign push_data   = byte_data;
    assign fmt_busy    = 1'b0;
`endif

    assign tx         = tx_q | rst;
    assign busy       = !rst && (!empty || state != S_IDLE || fmt_busy);
    assign fifo_level = rst ? '0 : level;

endmodule

// File: tb/tb_uart_report_tx.sv
// Directed self-checking bench for uart_report_tx (DIV=10, FIFO_DEPTH=4).
// Covers the hex formatter when compiled with UART_HEX_EN, the tie-off otherwise.
`timescale 1ns/1ps
module tb_uart_report_tx;

    localparam int unsigned DIV = 10;

    logic        high_clk = 1'b0;
    logic        rst = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        word_valid = 1'b0;
    logic [31:0] word_data = '0;
    logic        byte_ready;
    logic        word_ready;
    logic        tx;
    logic        busy;
    logic [2:0]  fifo_level;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

`ifdef UART_HEX_EN
    localparam logic WR_EXP = 1'b1;
`else
    localparam logic WR_EXP = 1'b0;
`endif

    uart_report_tx #(
        .CLK_FREQ  (1_000_000),
        .BAUD_RATE (100_000),
        .FIFO_DEPTH(4),
        .STOP_BITS (1)
    ) dut (
        .high_clk  (high_clk),
        .rst       (rst),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .word_valid(word_valid),
        .word_data (word_data),
        .word_ready(word_ready),
        .tx        (tx),
        .busy      (busy),
        .fifo_level(fifo_level)
    );

    always #5 high_clk = ~high_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge high_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_tx_low(input string tag);
        int unsigned n = 0;
        while (tx !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_start_seen"}, {31'b0, tx}, 32'd0);
    endtask

    // Called on the first low cycle; returns on the last stop-bit cycle.
    task automatic check_frame(input string tag, input logic [7:0] b);
        int unsigned bad = 0;
        logic e;
        for (int k = 0; k < 100; k++) begin
            if (k > 0) tick();
            e = (k < 10) ? 1'b0 : (k < 90) ? b[(k - 10) / 10] : 1'b1;
            if (tx !== e) bad++;
        end
        check(tag, bad, 32'd0);
    endtask

    task automatic rx_byte(input string tag, input logic [7:0] exp);
        logic [7:0] b;
        wait_tx_low(tag);
        repeat (DIV / 2) tick();
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) tick();
            b[i] = tx;
        end
        repeat (DIV) tick();
        check({tag, "_stop"}, {31'b0, tx}, 32'd1);
        check(tag, {24'b0, b}, {24'b0, exp});
    endtask

    task automatic wait_idle(input string tag);
        int unsigned n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            tick();
            n++;
        end
        check(tag, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int unsigned bad;
        int unsigned n;
        logic [7:0] hex_exp [10];
        hex_exp = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};

        // Reset state
        repeat (3) tick();
        check("rst_tx", {31'b0, tx}, 32'd1);
        check("rst_byte_ready", {31'b0, byte_ready}, 32'd0);
        check("rst_word_ready", {31'b0, word_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_level", {29'b0, fifo_level}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_byte_ready", {31'b0, byte_ready}, 32'd1);
        check("post_rst_word_ready", {31'b0, word_ready}, {31'b0, WR_EXP});

        // Single byte 0x55: push at N, pop at N+1, tx low from N+2
        tick();
        byte_data = 8'h55;
        byte_valid = 1'b1;
        #1;
        check("single_ready", {31'b0, byte_ready}, 32'd1);
        tick();
        byte_valid = 1'b0;
        check("single_lvl_n", {29'b0, fifo_level}, 32'd1);
        check("single_tx_n", {31'b0, tx}, 32'd1);
        check("single_busy_n", {31'b0, busy}, 32'd1);
        tick();
        check("single_lvl_n1", {29'b0, fifo_level}, 32'd0);
        check("single_tx_n1", {31'b0, tx}, 32'd1);
        tick();
        check_frame("single_frame_55", 8'h55);
        tick();
        check("single_busy_after", {31'b0, busy}, 32'd0);
        check("single_tx_idle", {31'b0, tx}, 32'd1);

        // Back-to-back 0x41, 0x42
        tick();
        byte_data = 8'h41;
        byte_valid = 1'b1;
        tick();
        check("b2b_lvl_first", {29'b0, fifo_level}, 32'd1);
        byte_data = 8'h42;
        tick();
        check("b2b_lvl_pushpop", {29'b0, fifo_level}, 32'd1);
        byte_valid = 1'b0;
        tick();
        check_frame("b2b_frame_41", 8'h41);
        check("b2b_lvl_second_pop", {29'b0, fifo_level}, 32'd0);
        check("b2b_busy_mid", {31'b0, busy}, 32'd1);
        tick();
        check_frame("b2b_frame_42", 8'h42);
        tick();
        check("b2b_busy_end", {31'b0, busy}, 32'd0);

        // FIFO full: 0x11 in flight, then 5 pushes
        tick();
        byte_data = 8'h11;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
        tick();
        for (int i = 1; i <= 4; i++) begin
            byte_data = 8'(i);
            byte_valid = 1'b1;
            tick();
        end
        byte_data = 8'h05;
        #1;
        check("full_lvl", {29'b0, fifo_level}, 32'd4);
        check("full_ready_low", {31'b0, byte_ready}, 32'd0);
        n = 0;
        while (byte_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("full_resume", {31'b0, byte_ready}, 32'd1);
        check("full_lvl_after_pop", {29'b0, fifo_level}, 32'd3);
        tick();
        byte_valid = 1'b0;
        check("full_lvl_refill", {29'b0, fifo_level}, 32'd4);
        for (int i = 1; i <= 5; i++) begin
            rx_byte($sformatf("full_order%0d", i), 8'(i));
        end
        wait_idle("full_idle");

`ifdef UART_HEX_EN
        // Hex dump of 0xDEADBEEF with a competing byte request
        tick();
        word_data = 32'hDEADBEEF;
        word_valid = 1'b1;
        byte_data = 8'h99;
        byte_valid = 1'b1;
        #1;
        check("hex_word_ready", {31'b0, word_ready}, 32'd1);
        check("hex_byte_blocked", {31'b0, byte_ready}, 32'd0);
        tick();
        word_valid = 1'b0;
        #1;
        check("hex_word_ready_low", {31'b0, word_ready}, 32'd0);
        check("hex_busy", {31'b0, busy}, 32'd1);
        bad = 0;
        for (int i = 0; i < 2; i++) begin
            if (byte_ready !== 1'b0) bad++;
            tick();
        end
        check("hex_byte_held_off", bad, 32'd0);
        byte_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rx_byte($sformatf("hex_char%0d", i), hex_exp[i]);
            if (i == 4) check("hex_word_ready_mid", {31'b0, word_ready}, 32'd0);
        end
        wait_idle("hex_idle");
        check("hex_word_ready_end", {31'b0, word_ready}, 32'd1);
`else
        // Word port ignored without the formatter
        tick();
        word_data = 32'h12345678;
        word_valid = 1'b1;
        #1;
        check("noh_word_ready", {31'b0, word_ready}, 32'd0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (tx !== 1'b1 || word_ready !== 1'b0 || busy !== 1'b0) bad++;
            tick();
        end
        check("noh_line_quiet", bad, 32'd0);
        byte_data = 8'h55;
        byte_valid = 1'b1;
        #1;
        check("noh_byte_ready", {31'b0, byte_ready}, 32'd1);
        tick();
        byte_valid = 1'b0;
        tick();
        tick();
        check_frame("noh_frame_55", 8'h55);
        word_valid = 1'b0;
        wait_idle("noh_idle");
`endif

        // Reset during data bit 3 of 0xA5 with two bytes queued
        tick();
        byte_data = 8'hA5;
        byte_valid = 1'b1;
        tick();
        byte_data = 8'hC3;
        tick();
        byte_data = 8'h96;
        tick();
        byte_valid = 1'b0;
        check("mid_lvl_queued", {29'b0, fifo_level}, 32'd2);
        repeat (40) tick();
        check("mid_pre_bit3", {31'b0, tx}, 32'd0);
        rst = 1'b1;
        tick();
        check("mid_rst_tx", {31'b0, tx}, 32'd1);
        check("mid_rst_lvl", {29'b0, fifo_level}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_byte_ready", {31'b0, byte_ready}, 32'd0);
        check("mid_rst_word_ready", {31'b0, word_ready}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("mid_release_byte_ready", {31'b0, byte_ready}, 32'd1);
        check("mid_release_word_ready", {31'b0, word_ready}, {31'b0, WR_EXP});
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("mid_no_more_frames", bad, 32'd0);
        byte_data = 8'h3C;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
        tick();
        tick();
        check_frame("mid_new_frame_3c", 8'h3C);
        wait_idle("mid_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_report_tx.md
UART_REPORT_TX -- requirements
Module: uart_report_tx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 48_000_000, meaning the high_clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115_200, meaning the line bit rate.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16, meaning TX FIFO entries; it must be a power of 2 and at least 2.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values are 1 or 2.
REQ-005 The block SHALL have port high_clk, input, 1 bit: the clock; all logic runs on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 The block SHALL have port byte_valid, input, 1 bit: byte port request.
REQ-008 The block SHALL have port byte_data, input, 8 bits: byte to send.
REQ-009 The block SHALL have port byte_ready, output, 1 bit: byte accepted when high together with byte_valid.
REQ-010 The block SHALL have port word_valid, input, 1 bit: hex-dump request.
REQ-011 The block SHALL have port word_data, input, 32 bits: word to print.
REQ-012 The block SHALL have port word_ready, output, 1 bit: word accepted when high together with word_valid.
REQ-013 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-014 The block SHALL have port busy, output, 1 bit: high when the FIFO is non-empty, the serializer is not IDLE, or the formatter is active.
REQ-015 The block SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-016 Bit period DIV SHALL be floor(CLK_FREQ/BAUD_RATE) cycles, and every tx bit SHALL last exactly DIV cycles.
REQ-017 Frame format SHALL be: one start bit (0), then 8 data bits LSB first, then STOP_BITS stop bits (1).
REQ-018 Serializer states SHALL be IDLE -> START -> DATA (8 bits) -> STOP -> IDLE, or STOP -> START directly when the FIFO is non-empty at the end of the last stop-bit period (no idle gap).
REQ-019 byte_ready SHALL equal: not full, AND formatter idle, AND not word_valid (formatter enabled), AND not rst.
REQ-020 Latency: a byte accepted at edge N into an empty FIFO with an IDLE serializer SHALL be popped at N+1, and tx SHALL go low from edge N+2.
REQ-021 A simultaneous push and pop SHALL leave fifo_level unchanged.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 While the FIFO is full there SHALL be no push, and data SHALL never be overwritten.
REQ-024 Formatter: word_ready SHALL be high when the formatter is idle and rst is low.
REQ-025 An accepted word SHALL produce 10 FIFO pushes in order: 8 uppercase ASCII hex digits, MS nibble first ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46), then 0x0D, then 0x0A.
REQ-026 The formatter SHALL push at most one character per cycle, and SHALL stall while the FIFO is full.
REQ-027 The formatter SHALL return to idle on the cycle after its 10th push.
REQ-028 When byte_valid and word_valid arrive in the same cycle, the word SHALL win.

Reset
REQ-029 While rst is high: tx=1, byte_ready=0, word_ready=0, busy=0, fifo_level=0.
REQ-030 On reset, the serializer SHALL go to IDLE and the formatter SHALL go to idle.
REQ-031 Reset mid-frame SHALL drive tx high on the next edge, discard FIFO contents and any in-flight word, and SHALL NOT complete the partial frame.
REQ-032 After rst deasserts, byte_ready and word_ready SHALL rise in the first cycle.

Configuration
REQ-033 Macro UART_HEX_EN SHALL control the hex formatter. When defined, the formatter is built as in REQ-024..REQ-028.
REQ-034 When UART_HEX_EN is undefined: no formatter logic, word_ready tied 0, word_valid and word_data ignored, and byte_ready equals not full and not rst.

Verification (CLK_FREQ=1_000_000, BAUD_RATE=100_000, so DIV=10; FIFO_DEPTH=4)
REQ-035 Single byte: push 0x55 at edge N -> tx low at N+2 for 10 cycles; then bits 1,0,1,0,1,0,1,0 at 10 cycles each; then stop high; total frame 100 cycles; busy drops after the stop bit.
REQ-036 Back-to-back: push 0x41 and 0x42 in consecutive cycles -> two frames with zero idle cycles between them; fifo_level sequence 1, 1 (simultaneous push/pop), 0.
REQ-037 Full: push 5 bytes in 5 consecutive cycles while the serializer is busy -> byte_ready low once fifo_level reaches 4; no byte lost; the 5th byte is accepted after the first pop; wire order equals push order.
REQ-038 Hex (UART_HEX_EN): word 0xDEADBEEF -> bytes on the wire "DEADBEEF\r\n" (0x44 0x45 0x41 0x44 0x42 0x45 0x45 0x46 0x0D 0x0A); word_ready low until the last push; a concurrent byte_valid is held off.
REQ-039 Reset mid-frame: assert rst during data bit 3 of 0xA5 with 2 bytes queued -> tx=1 and fifo_level=0 on the next edge; no further frames; a new byte after reset frames correctly.
REQ-040 Without UART_HEX_EN: drive word_valid=1 with word 0x12345678 -> word_ready stays 0, tx stays high, and the byte port works as in REQ-035.
